// File: rtl/rename_reg_file_pkg.sv
// rename_reg_file_pkg
// Shared types and default constants for the multi-lane rename register file.
//   XLEN_DEF / ARCH_REGS_DEF / TAG_W_DEF / LANES_DEF / CDB_PORTS_DEF : default
//   parameter values used by rename_reg_file and rf_lookup_port.
//   rf_tag_t : rename tag type at the default tag width.
//   rf_src_t : one resolved source operand {data, tag, ready}.
// Optional feature macro used by the design: RENAME_REG_FILE_BYPASS_EN.
package rename_reg_file_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned ARCH_REGS_DEF = 32;
    localparam int unsigned TAG_W_DEF     = 6;
    localparam int unsigned LANES_DEF     = 2;
    localparam int unsigned CDB_PORTS_DEF = 2;

    typedef logic [TAG_W_DEF-1:0] rf_tag_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] data;
        rf_tag_t             tag;
        logic                ready;
    } rf_src_t;

endpackage

// File: rtl/rename_reg_file_lookup.sv
// rf_lookup_port
// Resolves one source operand of one rename lane.
//   src                 : architectural source index
//   base_data/tag/busy  : the register file entry for src
//   q_rename/q_rd/q_tag : all lanes' rename requests of this cycle
//   cdb_valid/tag/data  : result buses of this cycle (bypass only)
//   src_data/tag/ready  : resolved operand
// Priority: a rename of src by an older lane (j < LANE, highest j wins) beats
// the file entry; with RENAME_REG_FILE_BYPASS_EN defined, a busy entry whose
// producer broadcasts this cycle is satisfied from the lowest matching bus.
module rf_lookup_port
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned AW        = 5,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned CDB_PORTS = CDB_PORTS_DEF,
    parameter int unsigned LANE      = 0
) (
    input  logic [AW-1:0]                    src,
    input  logic [XLEN-1:0]                  base_data,
    input  logic [TAG_W-1:0]                 base_tag,
    input  logic                             base_busy,
    input  logic [LANES-1:0]                 q_rename,
    input  logic [LANES-1:0][AW-1:0]         q_rd,
    input  logic [LANES-1:0][TAG_W-1:0]      q_tag,
    input  logic [CDB_PORTS-1:0]             cdb_valid,
    input  logic [CDB_PORTS-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [CDB_PORTS-1:0][XLEN-1:0]   cdb_data,
    output logic [XLEN-1:0]                  src_data,
    output logic [TAG_W-1:0]                 src_tag,
    output logic                             src_ready
);

    logic intra_hit_s;
    // Younger lanes and (without bypass) the result buses are not consulted.
    logic unused_s;
    assign unused_s = ^{q_rename, q_rd, q_tag, cdb_valid, cdb_tag, cdb_data};

`ifdef RENAME_REG_FILE_BYPASS_EN
    logic byp_hit_s;
`endif

    // Operand resolution: file entry, then older-lane rename, then bypass.
    always_comb begin
        src_data    = base_data;
        src_tag     = base_tag;
        src_ready   = ~base_busy;
        intra_hit_s = 1'b0;
        // Ascending scan so the highest older lane overrides lower ones.
        for (int j = 0; j < int'(LANE); j++) begin
            if (q_rename[j] && (q_rd[j] == src) && (src != {AW{1'b0}})) begin
                intra_hit_s = 1'b1;
                src_data    = {XLEN{1'b0}};
                src_tag     = q_tag[j];
                src_ready   = 1'b0;
            end else begin
                intra_hit_s = intra_hit_s;
            end
        end
`ifdef RENAME_REG_FILE_BYPASS_EN
        byp_hit_s = 1'b0;
        // First (lowest) matching bus wins; only the base case is bypassed.
        for (int k = 0; k < int'(CDB_PORTS); k++) begin
            if (!intra_hit_s && !byp_hit_s && base_busy &&
                cdb_valid[k] && (cdb_tag[k] == base_tag)) begin
                byp_hit_s = 1'b1;
                src_data  = cdb_data[k];
                src_ready = 1'b1;
            end else begin
                byp_hit_s = byp_hit_s;
            end
        end
`endif
    end

endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file
// Architectural register file with per-register rename tags, LANES rename
// lanes and CDB_PORTS result-bus writeback ports per cycle.
//   clk, rst_n         : clock, async active-low reset
//   flush              : clear every busy bit (values kept)
//   q_rs1/q_rs2/q_rd   : per-lane source / destination indices
//   q_rename, q_tag    : per-lane destination rename request and new tag
//   s1_*/s2_*          : per-lane resolved sources {data, tag, ready}
//   cdb_valid/tag/rd/data : result buses
// Optional macro: RENAME_REG_FILE_BYPASS_EN enables same-cycle result-bus
// bypass into the source lookup (see rf_lookup_port).
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned ARCH_REGS = ARCH_REGS_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned CDB_PORTS = CDB_PORTS_DEF,
    localparam int unsigned AW       = $clog2(ARCH_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [LANES-1:0][AW-1:0]         q_rs1,
    input  logic [LANES-1:0][AW-1:0]         q_rs2,
    input  logic [LANES-1:0][AW-1:0]         q_rd,
    input  logic [LANES-1:0]                 q_rename,
    input  logic [LANES-1:0][TAG_W-1:0]      q_tag,
    output logic [LANES-1:0][XLEN-1:0]       s1_data,
    output logic [LANES-1:0][XLEN-1:0]       s2_data,
    output logic [LANES-1:0][TAG_W-1:0]      s1_tag,
    output logic [LANES-1:0][TAG_W-1:0]      s2_tag,
    output logic [LANES-1:0]                 s1_ready,
    output logic [LANES-1:0]                 s2_ready,
    input  logic [CDB_PORTS-1:0]             cdb_valid,
    input  logic [CDB_PORTS-1:0][TAG_W-1:0]  cdb_tag,
    input  logic [CDB_PORTS-1:0][AW-1:0]     cdb_rd,
    input  logic [CDB_PORTS-1:0][XLEN-1:0]   cdb_data
);

    logic [ARCH_REGS-1:0][XLEN-1:0]  value_r;
    logic [ARCH_REGS-1:0][TAG_W-1:0] tag_r;
    logic [ARCH_REGS-1:0]            busy_r;

    // Register state: writeback first, then renames override busy/tag, then
    // flush overrides every busy update. Entry 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= '0;
            tag_r   <= '0;
            busy_r  <= '0;
        end else begin
            for (int k = 0; k < int'(CDB_PORTS); k++) begin
                // A mismatching tag is a stale producer and is dropped.
                if (cdb_valid[k] && (cdb_rd[k] != {AW{1'b0}}) &&
                    busy_r[cdb_rd[k]] && (tag_r[cdb_rd[k]] == cdb_tag[k])) begin
                    value_r[cdb_rd[k]] <= cdb_data[k];
                    busy_r[cdb_rd[k]]  <= 1'b0;
                end else begin
                    value_r[0] <= {XLEN{1'b0}};
                end
            end
            if (flush) begin
                busy_r <= '0;
            end else begin
                // Ascending order: the highest lane renaming a register wins.
                for (int i = 0; i < int'(LANES); i++) begin
                    if (q_rename[i] && (q_rd[i] != {AW{1'b0}})) begin
                        busy_r[q_rd[i]] <= 1'b1;
                        tag_r[q_rd[i]]  <= q_tag[i];
                    end else begin
                        busy_r[0] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        rf_lookup_port #(
            .XLEN(XLEN), .TAG_W(TAG_W), .AW(AW), .LANES(LANES),
            .CDB_PORTS(CDB_PORTS), .LANE(i)
        ) u_src1 (
            .src       (q_rs1[i]),
            .base_data (value_r[q_rs1[i]]),
            .base_tag  (tag_r[q_rs1[i]]),
            .base_busy (busy_r[q_rs1[i]]),
            .q_rename  (q_rename),
            .q_rd      (q_rd),
            .q_tag     (q_tag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .src_data  (s1_data[i]),
            .src_tag   (s1_tag[i]),
            .src_ready (s1_ready[i])
        );

        rf_lookup_port #(
            .XLEN(XLEN), .TAG_W(TAG_W), .AW(AW), .LANES(LANES),
            .CDB_PORTS(CDB_PORTS), .LANE(i)
        ) u_src2 (
            .src       (q_rs2[i]),
            .base_data (value_r[q_rs2[i]]),
            .base_tag  (tag_r[q_rs2[i]]),
            .base_busy (busy_r[q_rs2[i]]),
            .q_rename  (q_rename),
            .q_rd      (q_rd),
            .q_tag     (q_tag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .src_data  (s2_data[i]),
            .src_tag   (s2_tag[i]),
            .src_ready (s2_ready[i])
        );
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file
// Directed bench for rename_reg_file at default parameters. Expected values
// are hand-computed; bypass-dependent expectations follow
// RENAME_REG_FILE_BYPASS_EN.
module tb_rename_reg_file;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned AW = 5;
    localparam int unsigned LANES = 2;
    localparam int unsigned CDB_PORTS = 2;

    logic                            clk;
    logic                            rst_n;
    logic                            flush;
    logic [LANES-1:0][AW-1:0]        q_rs1;
    logic [LANES-1:0][AW-1:0]        q_rs2;
    logic [LANES-1:0][AW-1:0]        q_rd;
    logic [LANES-1:0]                q_rename;
    logic [LANES-1:0][TAG_W-1:0]     q_tag;
    logic [LANES-1:0][XLEN-1:0]      s1_data;
    logic [LANES-1:0][XLEN-1:0]      s2_data;
    logic [LANES-1:0][TAG_W-1:0]     s1_tag;
    logic [LANES-1:0][TAG_W-1:0]     s2_tag;
    logic [LANES-1:0]                s1_ready;
    logic [LANES-1:0]                s2_ready;
    logic [CDB_PORTS-1:0]            cdb_valid;
    logic [CDB_PORTS-1:0][TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS-1:0][AW-1:0]    cdb_rd;
    logic [CDB_PORTS-1:0][XLEN-1:0]  cdb_data;

    int n_cmp;
    int n_bad;

    rename_reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_rd      (q_rd),
        .q_rename  (q_rename),
        .q_tag     (q_tag),
        .s1_data   (s1_data),
        .s2_data   (s2_data),
        .s1_tag    (s1_tag),
        .s2_tag    (s2_tag),
        .s1_ready  (s1_ready),
        .s2_ready  (s2_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_rd    (cdb_rd),
        .cdb_data  (cdb_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        q_rs1     = '0;
        q_rs2     = '0;
        q_rd      = '0;
        q_rename  = '0;
        q_tag     = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_rd    = '0;
        cdb_data  = '0;
    endtask

    // Advance one rising edge and step just past it before driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        q_rs1[0] = 5'd5;
        q_rs2[1] = 5'd31;
        #2;
        check("rst_s1_ready", {31'd0, s1_ready[0]}, 32'd1);
        check("rst_s1_data", s1_data[0], 32'd0);
        check("rst_s2_tag", {26'd0, s2_tag[1]}, 32'd0);
        check("rst_s2_ready", {31'd0, s2_ready[1]}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Rename x5 -> tag 9 on lane 0.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd5; q_tag[0] = 6'd9;
        tick();
        idle();
        q_rs1[1] = 5'd5;
        #1;
        check("x5_busy_ready", {31'd0, s1_ready[1]}, 32'd0);
        check("x5_busy_tag", {26'd0, s1_tag[1]}, 32'd9);

        // Result bus retires tag 9 into x5.
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd9; cdb_rd[0] = 5'd5; cdb_data[0] = 32'hDEAD;
        #1;
`ifdef RENAME_REG_FILE_BYPASS_EN
        check("x5_byp_ready", {31'd0, s1_ready[1]}, 32'd1);
        check("x5_byp_data", s1_data[1], 32'hDEAD);
`else
        check("x5_nobyp_ready", {31'd0, s1_ready[1]}, 32'd0);
        check("x5_nobyp_tag", {26'd0, s1_tag[1]}, 32'd9);
`endif
        tick();
        idle();
        q_rs1[1] = 5'd5;
        #1;
        check("x5_wb_ready", {31'd0, s1_ready[1]}, 32'd1);
        check("x5_wb_data", s1_data[1], 32'hDEAD);

        // Intra-group: lane 0 renames x3 while lane 1 reads it.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd3; q_tag[0] = 6'd4;
        q_rs1[0] = 5'd3; q_rs1[1] = 5'd3; q_rs2[1] = 5'd5;
        #1;
        check("intra_l1_ready", {31'd0, s1_ready[1]}, 32'd0);
        check("intra_l1_tag", {26'd0, s1_tag[1]}, 32'd4);
        check("intra_l1_data", s1_data[1], 32'd0);
        check("intra_l0_ready", {31'd0, s1_ready[0]}, 32'd1);
        check("intra_l1_s2_data", s2_data[1], 32'hDEAD);
        tick();

        // Both lanes rename x3; highest lane's tag sticks.
        idle();
        q_rename = 2'b11; q_rd[0] = 5'd3; q_rd[1] = 5'd3; q_tag[0] = 6'd4; q_tag[1] = 6'd7;
        tick();
        idle();
        q_rs2[0] = 5'd3;
        #1;
        check("dual_ren_tag", {26'd0, s2_tag[0]}, 32'd7);
        check("dual_ren_ready", {31'd0, s2_ready[0]}, 32'd0);

        // Stale producer (tag 4) for x3 is ignored.
        cdb_valid[1] = 1'b1; cdb_tag[1] = 6'd4; cdb_rd[1] = 5'd3; cdb_data[1] = 32'h1234;
        #1;
        check("stale_byp_ready", {31'd0, s2_ready[0]}, 32'd0);
        tick();
        idle();
        q_rs2[0] = 5'd3;
        #1;
        check("stale_ready", {31'd0, s2_ready[0]}, 32'd0);
        check("stale_tag", {26'd0, s2_tag[0]}, 32'd7);
        check("stale_data", s2_data[0], 32'd0);

        // Bypass case on x8.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd8; q_tag[0] = 6'd2;
        tick();
        idle();
        q_rs1[0] = 5'd8;
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd2; cdb_rd[0] = 5'd8; cdb_data[0] = 32'h55;
        #1;
`ifdef RENAME_REG_FILE_BYPASS_EN
        check("x8_byp_ready", {31'd0, s1_ready[0]}, 32'd1);
        check("x8_byp_data", s1_data[0], 32'h55);
`else
        check("x8_nobyp_ready", {31'd0, s1_ready[0]}, 32'd0);
        check("x8_nobyp_tag", {26'd0, s1_tag[0]}, 32'd2);
`endif
        tick();
        idle();
        q_rs1[0] = 5'd8;
        #1;
        check("x8_wb_data", s1_data[0], 32'h55);
        check("x8_wb_ready", {31'd0, s1_ready[0]}, 32'd1);

        // Writeback and re-rename of x9 in the same cycle.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd9; q_tag[0] = 6'd10;
        tick();
        idle();
        cdb_valid[1] = 1'b1; cdb_tag[1] = 6'd10; cdb_rd[1] = 5'd9; cdb_data[1] = 32'hAB;
        q_rename[0] = 1'b1; q_rd[0] = 5'd9; q_tag[0] = 6'd11;
        tick();
        idle();
        q_rs2[1] = 5'd9;
        #1;
        check("wbren_ready", {31'd0, s2_ready[1]}, 32'd0);
        check("wbren_tag", {26'd0, s2_tag[1]}, 32'd11);
        check("wbren_data", s2_data[1], 32'hAB);

        // x6 gets value 0x66, renamed, then flushed alongside a new rename.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd6; q_tag[0] = 6'd12;
        tick();
        idle();
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd12; cdb_rd[0] = 5'd6; cdb_data[0] = 32'h66;
        tick();
        idle();
        q_rename[1] = 1'b1; q_rd[1] = 5'd6; q_tag[1] = 6'd13;
        tick();
        idle();
        flush = 1'b1;
        q_rename[0] = 1'b1; q_rd[0] = 5'd6; q_tag[0] = 6'd14;
        tick();
        idle();
        q_rs1[1] = 5'd6;
        #1;
        check("flush_ready", {31'd0, s1_ready[1]}, 32'd1);
        check("flush_data", s1_data[1], 32'h66);

        // Flush in the same cycle as a writeback still stores the value.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd10; q_tag[0] = 6'd15;
        tick();
        idle();
        flush = 1'b1;
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd15; cdb_rd[0] = 5'd10; cdb_data[0] = 32'h77;
        tick();
        idle();
        q_rs2[0] = 5'd10;
        #1;
        check("flush_wb_ready", {31'd0, s2_ready[0]}, 32'd1);
        check("flush_wb_data", s2_data[0], 32'h77);

        // x0 ignores renames and writes.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd0; q_tag[0] = 6'd20;
        cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd0; cdb_rd[0] = 5'd0; cdb_data[0] = 32'hFF;
        q_rs1[1] = 5'd0;
        #1;
        check("x0_intra_ready", {31'd0, s1_ready[1]}, 32'd1);
        tick();
        idle();
        q_rs1[1] = 5'd0;
        #1;
        check("x0_ready", {31'd0, s1_ready[1]}, 32'd1);
        check("x0_data", s1_data[1], 32'd0);
        check("x0_tag", {26'd0, s1_tag[1]}, 32'd0);

        // Mid-run asynchronous reset clears busy state and values.
        idle();
        q_rename[0] = 1'b1; q_rd[0] = 5'd5; q_tag[0] = 6'd21;
        tick();
        idle();
        q_rs1[0] = 5'd5; q_rs2[0] = 5'd8;
        #1;
        check("pre_rst_ready", {31'd0, s1_ready[0]}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, s1_ready[0]}, 32'd1);
        check("mid_rst_tag", {26'd0, s1_tag[0]}, 32'd0);
        check("mid_rst_data", s1_data[0], 32'd0);
        check("mid_rst_x8_data", s2_data[0], 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
